vga_receiver: RTL and testbench

VGA_RECEIVER -- requirements
Module: vga_receiver

---
 rtl/vga_receiver.sv | 184 ++++++++++++++++++
 tb/tb_vga_receiver.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_receiver.sv
// VGA timing receiver: recovers active-area pixel coordinates from sync/blank inputs,
// measures line and frame length, and locks after consecutive good frames.
module vga_receiver #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    input  logic [7:0] color_in,
    input  logic       err_clear,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [7:0] pixel_color,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic       w_err
);
    localparam logic [9:0] CntMax  = 10'd1023;
    localparam logic [9:0] HTotal  = 10'(H_TOTAL);
    localparam logic [9:0] VTotal  = 10'(V_TOTAL);
    localparam logic [9:0] HActive = 10'(H_ACTIVE);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_t;
    state_t state;

    logic       hs_s1, vs_s1, bl_s1, hs_s2, vs_s2, bl_s2;
    logic [7:0] col_s1;
    logic [9:0] h_count, v_count, run_len;
    logic       first_line, first_frame, frame_bad;
    logic [7:0] good_cnt;

    logic       line_b, frame_b, bl_fall, h_sat;
    logic [9:0] h_meas, v_meas, px_next, py_next;
    logic       h_mis, v_mis, w_mis, any_mis;

    always_comb begin
        line_b  = hs_s2 & ~hs_s1;
        frame_b = vs_s2 & ~vs_s1;
        bl_fall = bl_s2 & ~bl_s1;
        h_sat   = (h_count == CntMax);
        h_meas  = h_sat ? CntMax : h_count + 10'd1;
        // A line boundary coinciding with the frame boundary belongs to the ending frame.
        v_meas  = (line_b && v_count != CntMax) ? v_count + 10'd1 : v_count;
        h_mis   = line_b & ~first_line & (h_meas != HTotal);
        v_mis   = frame_b & ~first_frame & (v_meas != VTotal);
        w_mis   = bl_fall & ~first_line & (run_len != HActive);
        any_mis = h_mis | v_mis | w_mis;

        px_next = pixel_x;
        if (bl_s1) begin
            if (!bl_s2) px_next = '0;
            else if (pixel_x != CntMax) px_next = pixel_x + 10'd1;
        end
        py_next = pixel_y;
        if (frame_b) py_next = '0;
        else if (bl_fall && pixel_y != CntMax) py_next = pixel_y + 10'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {hs_s1, vs_s1, bl_s1, hs_s2, vs_s2, bl_s2} <= '0;
            col_s1       <= '0;
            h_count      <= '0;
            v_count      <= '0;
            run_len      <= '0;
            first_line   <= 1'b1;
            first_frame  <= 1'b1;
            frame_bad    <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            pixel_color  <= '0;
            pixel_valid  <= 1'b0;
            frame_start  <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
            w_err        <= 1'b0;
        end else begin
            hs_s1  <= hsync;
            vs_s1  <= vsync;
            bl_s1  <= blank;
            col_s1 <= color_in;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            bl_s2  <= bl_s1;

            if (line_b) h_count <= '0;
            else if (!h_sat) h_count <= h_count + 10'd1;

            if (line_b) begin
                h_total_meas <= h_meas;
                first_line   <= 1'b0;
            end

            if (frame_b) begin
                v_total_meas <= v_meas;
                v_count      <= '0;
                first_frame  <= 1'b0;
            end else if (line_b && v_count != CntMax) begin
                v_count <= v_count + 10'd1;
            end

            if (bl_s1) begin
                if (!bl_s2) run_len <= 10'd1;
                else if (run_len != CntMax) run_len <= run_len + 10'd1;
            end

            if (frame_b) frame_bad <= 1'b0;
            else if (any_mis) frame_bad <= 1'b1;

            pixel_valid <= bl_s1;
            pixel_color <= col_s1;
            pixel_x     <= px_next;
            pixel_y     <= py_next;
            frame_start <= bl_s1 & (px_next == '0) & (py_next == '0);

            // A new error in the same cycle as err_clear keeps the flag set.
            h_err <= h_mis | (h_err & ~err_clear);
            v_err <= v_mis | (v_err & ~err_clear);
            w_err <= w_mis | (w_err & ~err_clear);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StSearch;
            good_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            unique case (state)
                StSearch: begin
                    if (frame_b) begin
                        state    <= StMeasure;
                        good_cnt <= '0;
                    end
                end
                StMeasure: begin
                    if (h_sat) begin
                        state    <= StSearch;
                        good_cnt <= '0;
                    end else if (frame_b) begin
                        if (frame_bad || any_mis) begin
                            good_cnt <= '0;
                        end else if ({24'd0, good_cnt} + 32'd1 >= LOCK_FRAMES) begin
                            state    <= StLocked;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                end
                StLocked: begin
                    if (h_sat) begin
                        state    <= StSearch;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end else if (any_mis) begin
                        state    <= StMeasure;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= StSearch;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_receiver.sv
// Bench for vga_receiver on a scaled-down raster (40x12 clocks/lines, 16x8 active):
// a scoreboard checks the pixel stream, scenario tasks check timing, lock and errors.
`timescale 1ns/1ps
module tb_vga_receiver;
    localparam int HT       = 40;
    localparam int VT       = 12;
    localparam int HA       = 16;
    localparam int LF       = 2;
    localparam int HS_LEN   = 4;
    localparam int H_START  = 10;
    localparam int VS_LINES = 2;
    localparam int V_START  = 2;
    localparam int V_ROWS   = 8;

    typedef struct {
        int         stamp;
        int         x;
        int         y;
        logic [7:0] col;
        logic       fs;
    } exp_t;

    logic       clock, reset, hsync, vsync, blank, err_clear;
    logic [7:0] color_in;
    logic [9:0] pixel_x, pixel_y, h_total_meas, v_total_meas;
    logic [7:0] pixel_color;
    logic       pixel_valid, frame_start, locked, h_err, v_err, w_err;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    int   line_start_cyc = 0;
    int   frame_cycs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    bit   sb_on = 0;
    logic locked_prev = 1'b0;
    logic [53:0] all_out;

    vga_receiver #(
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .H_ACTIVE   (HA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .color_in    (color_in),
        .err_clear   (err_clear),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas),
        .locked      (locked),
        .h_err       (h_err),
        .v_err       (v_err),
        .w_err       (w_err)
    );

    assign all_out = {pixel_x, pixel_y, pixel_color, pixel_valid, frame_start, h_total_meas,
                      v_total_meas, locked, h_err, v_err, w_err};

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every valid output pixel must match the oldest expected entry, 2 clocks on.
    always @(negedge clock) begin
        if (locked === 1'b1 && locked_prev !== 1'b1) rise_cyc = cyc;
        if (locked === 1'b0 && locked_prev === 1'b1) fall_cyc = cyc;
        locked_prev = locked;
        if (sb_on && pixel_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_extra: pixel (%0d,%0d) appeared, none expected",
                         pixel_x, pixel_y);
            end else begin
                mon_e = sb_q.pop_front();
                if (pixel_x !== 10'(mon_e.x) || pixel_y !== 10'(mon_e.y) ||
                    pixel_color !== mon_e.col || frame_start !== mon_e.fs ||
                    cyc - mon_e.stamp != 2)
                    $display("FAIL sb_pixel: got (%0d,%0d) col %02h fs %0b lat %0d, want (%0d,%0d) col %02h fs %0b lat 2",
                             pixel_x, pixel_y, pixel_color, frame_start, cyc - mon_e.stamp,
                             mon_e.x, mon_e.y, mon_e.col, mon_e.fs);
                else
                    n_pass++;
            end
        end
    end

    task automatic step(input logic hs, input logic vs, input logic bl, input logic [7:0] col,
                        input logic clr, input int x, input int y);
        exp_t e;
        hsync     = hs;
        vsync     = vs;
        blank     = bl;
        color_in  = col;
        err_clear = clr;
        if (sb_on && bl) begin
            e.stamp = cyc;
            e.x     = x;
            e.y     = y;
            e.col   = col;
            e.fs    = (x == 0 && y == 0);
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0);
    endtask

    task automatic drive_line(input int l, input int len, input int act, input int clr_at);
        logic hs, vs, bl;
        line_start_cyc = cyc;
        if (l == 0) frame_cycs.push_back(cyc);
        for (int c = 0; c < len; c++) begin
            hs = (c >= HS_LEN);
            vs = (l >= VS_LINES);
            bl = (l >= V_START) && (l < V_START + V_ROWS) && (c >= H_START) &&
                 (c < H_START + act);
            step(hs, vs, bl, 8'($urandom_range(0, 255)), c == clr_at, c - H_START, l - V_START);
        end
    endtask

    task automatic drive_frame(input int nlines);
        for (int l = 0; l < nlines; l++) drive_line(l, HT, HA, -1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hsync = 1'b1; vsync = 1'b1; blank = 1'b0; color_in = 8'h00; err_clear = 1'b0;
        #3;
        n_checks++;
        if (all_out !== 54'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(5);
        n_checks++;
        if (all_out !== 54'd0) $display("FAIL idle_outputs: got %h want 0", all_out);
        else n_pass++;
    endtask

    task automatic test_nominal();
        sb_on = 1;
        drive_frame(VT);
        drive_frame(VT);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL lock_early: got %0b want 0", locked);
        else n_pass++;
        drive_frame(VT);
        drive_frame(VT);
        n_checks++;
        if (h_total_meas !== 10'(HT)) $display("FAIL h_total_meas: got %0d want %0d", h_total_meas, HT);
        else n_pass++;
        n_checks++;
        if (v_total_meas !== 10'(VT)) $display("FAIL v_total_meas: got %0d want %0d", v_total_meas, VT);
        else n_pass++;
        n_checks++;
        if ({locked, h_err, v_err, w_err} !== 4'b1000)
            $display("FAIL nominal_flags: got lock/h/v/w %b want 1000", {locked, h_err, v_err, w_err});
        else n_pass++;
        // Third boundary reaches S1 one clock after input; locked follows one clock later.
        n_checks++;
        if (rise_cyc - frame_cycs[2] != 2)
            $display("FAIL lock_timing: got %0d clocks want 2", rise_cyc - frame_cycs[2]);
        else n_pass++;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        sb_on = 0;
        for (int l = 0; l < 6; l++) drive_line(l, HT, HA, -1);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 54'd0) $display("FAIL async_reset: got %h want 0", all_out);
        else n_pass++;
        sb_q.delete();
        frame_cycs.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int l = 6; l < VT; l++) drive_line(l, HT, HA, -1);
        sb_on = 1;
        repeat (3) drive_frame(VT);
        n_checks++;
        if ({locked, h_err, v_err, w_err} !== 4'b1000)
            $display("FAIL post_reset_flags: got lock/h/v/w %b want 1000",
                     {locked, h_err, v_err, w_err});
        else n_pass++;
    endtask

    task automatic test_short_line();
        for (int l = 0; l < VT; l++) begin
            drive_line(l, (l == 5) ? HT - 1 : HT, HA, -1);
            if (l == 4) begin
                n_checks++;
                if (locked !== 1'b1) $display("FAIL pre_short_lock: got %0b want 1", locked);
                else n_pass++;
            end
            if (l == 6) begin
                n_checks++;
                if (h_total_meas !== 10'(HT - 1))
                    $display("FAIL short_meas: got %0d want %0d", h_total_meas, HT - 1);
                else n_pass++;
                n_checks++;
                if ({h_err, locked} !== 2'b10)
                    $display("FAIL short_flags: got h_err/locked %b want 10", {h_err, locked});
                else n_pass++;
                n_checks++;
                if (fall_cyc - line_start_cyc != 2)
                    $display("FAIL unlock_timing: got %0d clocks want 2", fall_cyc - line_start_cyc);
                else n_pass++;
            end
        end
        drive_frame(VT);
        drive_frame(VT);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_early: got %0b want 0", locked);
        else n_pass++;
        drive_line(0, HT, HA, -1);
        n_checks++;
        if ({locked, h_err} !== 2'b11)
            $display("FAIL relock: got locked/h_err %b want 11", {locked, h_err});
        else n_pass++;
        drive_line(1, HT, HA, 20);
        n_checks++;
        if (h_err !== 1'b0) $display("FAIL h_err_clear: got %0b want 0", h_err);
        else n_pass++;
        for (int l = 2; l < VT; l++) drive_line(l, HT, HA, -1);
    endtask

    task automatic test_sync_loss();
        idle(1100);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL sync_loss_lock: got %0b want 0", locked);
        else n_pass++;
        drive_line(0, HT, HA, -1);
        n_checks++;
        if (h_total_meas !== 10'd1023)
            $display("FAIL h_saturate: got %0d want 1023", h_total_meas);
        else n_pass++;
        for (int l = 1; l < VT; l++) drive_line(l, HT, HA, -1);
        repeat (3) drive_frame(VT);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL sync_relock: got %0b want 1", locked);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        drive_line(0, HT, HA, 5);
        n_checks++;
        if ({h_err, v_err, w_err} !== 3'b000)
            $display("FAIL err_clear_all: got h/v/w %b want 000", {h_err, v_err, w_err});
        else n_pass++;
        for (int l = 1; l < VT - 1; l++) drive_line(l, HT, HA, -1);
        drive_line(0, HT, HA, -1);
        n_checks++;
        if (v_total_meas !== 10'(VT - 1))
            $display("FAIL short_frame_meas: got %0d want %0d", v_total_meas, VT - 1);
        else n_pass++;
        n_checks++;
        if ({v_err, locked} !== 2'b10)
            $display("FAIL short_frame_flags: got v_err/locked %b want 10", {v_err, locked});
        else n_pass++;
        drive_line(1, HT, HA, 5);
        n_checks++;
        if (v_err !== 1'b0) $display("FAIL v_err_clear: got %0b want 0", v_err);
        else n_pass++;
        for (int l = 2; l < VT; l++) drive_line(l, HT, HA, -1);
    endtask

    task automatic test_err_clear();
        for (int l = 0; l < 4; l++) drive_line(l, HT, HA, -1);
        n_checks++;
        if (w_err !== 1'b0) $display("FAIL w_err_pre: got %0b want 0", w_err);
        else n_pass++;
        // err_clear lands on the same edge that registers the short-run error.
        drive_line(4, HT, HA - 1, H_START + HA);
        n_checks++;
        if (w_err !== 1'b1) $display("FAIL w_err_set_wins: got %0b want 1", w_err);
        else n_pass++;
        drive_line(5, HT, HA, 0);
        n_checks++;
        if (w_err !== 1'b0) $display("FAIL w_err_clear: got %0b want 0", w_err);
        else n_pass++;
        for (int l = 6; l < VT; l++) drive_line(l, HT, HA, -1);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_final_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mid_reset();
        test_short_line();
        test_sync_loss();
        test_short_frame();
        test_err_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
